// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store stage driving an asynchronous SRAM.
//
// Non-memory operations pass waddr/we/wdata through with one cycle of latency. Memory
// operations latch their operands, hold the SRAM strobes low for WAIT_CYCLES+1 cycles
// (stall_o high), then spend one DONE cycle presenting load data before returning to idle.
// Every output is a flop except stall_o, which is combinational so the request cycle
// itself stalls upstream.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   waddr_i/we_i/wdata_i   write-back request from the ALU stage
//   aluop_i           operation code (LB/LH/LW/LBU/LHU/SB/SH/SW use the *_OP defines)
//   mem_addr_i        effective address; reg2_i store data; flush_i squash
//   mem_data_i        SRAM read data
//   waddr_o/we_o/wdata_o   write-back result
//   stall_o           upstream hold
//   excp_o/badaddr_o  misalignment exception pulse and faulting address
//   mem_addr_o/mem_data_o  SRAM address and write data
//   mem_we_n_o/mem_oe_n_o/mem_ce_n_o/mem_be_n_o  SRAM strobes, active low
//
// Optional feature: define MEM_ALIGN_EXC_EN to trap misaligned half/word accesses instead
// of force-aligning them.

`ifndef LB_OP
`define LB_OP 5'h10
`endif
`ifndef LH_OP
`define LH_OP 5'h11
`endif
`ifndef LW_OP
`define LW_OP 5'h12
`endif
`ifndef LBU_OP
`define LBU_OP 5'h13
`endif
`ifndef LHU_OP
`define LHU_OP 5'h14
`endif
`ifndef SB_OP
`define SB_OP 5'h15
`endif
`ifndef SH_OP
`define SH_OP 5'h16
`endif
`ifndef SW_OP
`define SW_OP 5'h17
`endif

module mem_access_unit #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        waddr_i,
    input  logic              we_i,
    input  logic [31:0]       wdata_i,
    input  logic [4:0]        aluop_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       reg2_i,
    input  logic              flush_i,
    input  logic [31:0]       mem_data_i,
    output logic [4:0]        waddr_o,
    output logic              we_o,
    output logic [31:0]       wdata_o,
    output logic              stall_o,
    output logic              excp_o,
    output logic [ADDR_W-1:0] badaddr_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    output logic              mem_we_n_o,
    output logic              mem_oe_n_o,
    output logic              mem_ce_n_o,
    output logic [3:0]        mem_be_n_o
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;
    typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

    localparam logic [3:0] LastCnt = 4'(WAIT_CYCLES);

    function automatic logic is_mem_op(input logic [4:0] op);
        case (op)
            `LB_OP, `LH_OP, `LW_OP, `LBU_OP, `LHU_OP, `SB_OP, `SH_OP, `SW_OP: is_mem_op = 1'b1;
            default: is_mem_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_load_op(input logic [4:0] op);
        case (op)
            `LB_OP, `LH_OP, `LW_OP, `LBU_OP, `LHU_OP: is_load_op = 1'b1;
            default: is_load_op = 1'b0;
        endcase
    endfunction

    function automatic size_e op_size(input logic [4:0] op);
        case (op)
            `LB_OP, `LBU_OP, `SB_OP: op_size = SzByte;
            `LH_OP, `LHU_OP, `SH_OP: op_size = SzHalf;
            default:                 op_size = SzWord;
        endcase
    endfunction

    function automatic logic [3:0] lane_be_n(input size_e sz, input logic [1:0] lane);
        case (sz)
            SzByte:  lane_be_n = ~(4'b0001 << lane);
            SzHalf:  lane_be_n = lane[1] ? 4'b0011 : 4'b1100;
            default: lane_be_n = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input size_e sz, input logic [31:0] d);
        case (sz)
            SzByte:  store_data = {4{d[7:0]}};
            SzHalf:  store_data = {2{d[15:0]}};
            default: store_data = d;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [4:0] op, input logic [1:0] lane,
                                             input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        logic        sx;
        case (lane)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h  = lane[1] ? d[31:16] : d[15:0];
        sx = (op == `LB_OP) || (op == `LH_OP);
        case (op_size(op))
            SzByte:  load_ext = {{24{sx & b[7]}}, b};
            SzHalf:  load_ext = {{16{sx & h[15]}}, h};
            default: load_ext = d;
        endcase
    endfunction

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [4:0]         op_q, op_d;
    logic [1:0]         lane_q, lane_d;
    logic               kill_q, kill_d;
    logic [4:0]         waddr_q, waddr_d;
    logic               we_q, we_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [31:0]        mem_data_q, mem_data_d;
    logic               we_n_q, we_n_d;
    logic               oe_n_q, oe_n_d;
    logic               ce_n_q, ce_n_d;
    logic [3:0]         be_n_q, be_n_d;
    logic               stall_c;

    size_e              in_size;
    logic [ADDR_W-1:0]  align_mask;
    logic [ADDR_W-1:0]  addr_al;
    logic               trap_c;  // misaligned access that must trap instead of running

    assign in_size = op_size(aluop_i);

    // Clearing the low bits is a no-op for accesses that are already aligned, so the same
    // path serves both builds; only the default build ever sees misaligned addresses here.
    always_comb begin
        align_mask = '0;
        case (in_size)
            SzWord:  align_mask[1:0] = 2'b11;
            SzHalf:  align_mask[1:0] = 2'b01;
            default: align_mask[1:0] = 2'b00;
        endcase
        addr_al = mem_addr_i & ~align_mask;
    end

`ifdef MEM_ALIGN_EXC_EN
    logic              excp_q, excp_d;
    logic [ADDR_W-1:0] badaddr_q, badaddr_d;

    assign trap_c = ((in_size == SzWord) && (mem_addr_i[1:0] != 2'b00)) ||
                    ((in_size == SzHalf) && mem_addr_i[0]);

    always_comb begin
        excp_d    = 1'b0;
        badaddr_d = badaddr_q;
        if ((state_q == StIdle) && !flush_i && is_mem_op(aluop_i) && trap_c) begin
            excp_d    = 1'b1;
            badaddr_d = mem_addr_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            excp_q    <= 1'b0;
            badaddr_q <= '0;
        end else begin
            excp_q    <= excp_d;
            badaddr_q <= badaddr_d;
        end
    end

    assign excp_o    = excp_q;
    assign badaddr_o = badaddr_q;
`else
    assign trap_c    = 1'b0;
    assign excp_o    = 1'b0;
    assign badaddr_o = '0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        lane_d     = lane_q;
        kill_d     = kill_q;
        waddr_d    = waddr_q;
        we_d       = 1'b0;
        wdata_d    = wdata_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        we_n_d     = we_n_q;
        oe_n_d     = oe_n_q;
        ce_n_d     = ce_n_q;
        be_n_d     = be_n_q;
        stall_c    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (flush_i) begin
                    we_d = 1'b0;
                end else if (!is_mem_op(aluop_i)) begin
                    waddr_d = waddr_i;
                    we_d    = we_i;
                    wdata_d = wdata_i;
                end else if (!trap_c) begin
                    stall_c    = 1'b1;
                    state_d    = StAccess;
                    cnt_d      = '0;
                    op_d       = aluop_i;
                    lane_d     = addr_al[1:0];
                    kill_d     = 1'b0;
                    waddr_d    = waddr_i;
                    mem_addr_d = addr_al;
                    mem_data_d = is_load_op(aluop_i) ? 32'h0 : store_data(in_size, reg2_i);
                    be_n_d     = lane_be_n(in_size, addr_al[1:0]);
                    ce_n_d     = 1'b0;
                    oe_n_d     = !is_load_op(aluop_i);
                    we_n_d     = is_load_op(aluop_i);
                end
            end
            StAccess: begin
                stall_c = 1'b1;
                if (flush_i) begin
                    kill_d = 1'b1;
                end
                if (cnt_q == LastCnt) begin
                    state_d    = StDone;
                    ce_n_d     = 1'b1;
                    oe_n_d     = 1'b1;
                    we_n_d     = 1'b1;
                    be_n_d     = 4'b1111;
                    mem_addr_d = '0;
                    mem_data_d = '0;
                    // A flush seen at any point of the access still lets the SRAM cycle
                    // finish but drops the write-back.
                    we_d       = is_load_op(op_q) && !kill_q && !flush_i;
                    if (is_load_op(op_q)) begin
                        wdata_d = load_ext(op_q, lane_q, mem_data_i);
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            op_q       <= '0;
            lane_q     <= '0;
            kill_q     <= 1'b0;
            waddr_q    <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            we_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            ce_n_q     <= 1'b1;
            be_n_q     <= 4'b1111;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            lane_q     <= lane_d;
            kill_q     <= kill_d;
            waddr_q    <= waddr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            we_n_q     <= we_n_d;
            oe_n_q     <= oe_n_d;
            ce_n_q     <= ce_n_d;
            be_n_q     <= be_n_d;
        end
    end

    assign waddr_o    = waddr_q;
    assign we_o       = we_q;
    assign wdata_o    = wdata_q;
    assign stall_o    = stall_c & ~rst;
    assign mem_addr_o = mem_addr_q;
    assign mem_data_o = mem_data_q;
    assign mem_we_n_o = we_n_q;
    assign mem_oe_n_o = oe_n_q;
    assign mem_ce_n_o = ce_n_q;
    assign mem_be_n_o = be_n_q;

endmodule
